// File: rtl/fpu_sched.sv
// fpu_sched: round-robin two-requester front end for a shared registered fpu; divide answered locally.
// Define FPU_SCHED_STATS_EN to build the per-requester issue counters.
module fpu_sched #(
  parameter int LATENCY = 1,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid0,
  output logic        req_ready0,
  input  logic [15:0] req_a0,
  input  logic [15:0] req_b0,
  input  logic [1:0]  req_op0,
  input  logic        req_valid1,
  output logic        req_ready1,
  input  logic [15:0] req_a1,
  input  logic [15:0] req_b1,
  input  logic [1:0]  req_op1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  input  logic        rsp_ready0,
  input  logic        rsp_ready1,
  output logic [15:0] rsp_out,
  output logic [5:0]  rsp_flag,
  output logic [15:0] fpu_a,
  output logic [15:0] fpu_b,
  output logic [1:0]  fpu_opcode,
  input  logic [15:0] fpu_out,
  input  logic [5:0]  fpu_flag,
  output logic        busy,
  output logic [15:0] stat_issue0,
  output logic [15:0] stat_issue1
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ptr_q, ptr_d, gid_q, gid_d;
  logic [15:0] out_q, out_d, a_q, a_d, b_q, b_d;
  logic [5:0] flag_q, flag_d;
  logic [1:0] op_q, op_d;
  logic gnt, acc, div, hs;
  // the pointer only matters when both requesters compete
  assign gnt = (req_valid0 && req_valid1) ? ptr_q : req_valid1;
  assign acc = rst_n && state_q == IDLE && (req_valid0 || req_valid1);
  assign div = (gnt ? req_op1 : req_op0) == 2'b11;
  assign hs = state_q == RESP && (gid_q ? rsp_ready1 : rsp_ready0);
  assign req_ready0 = acc && !gnt;
  assign req_ready1 = acc && gnt;
  assign rsp_valid0 = state_q == RESP && !gid_q;
  assign rsp_valid1 = state_q == RESP && gid_q;
  assign rsp_out = out_q;
  assign rsp_flag = flag_q;
  assign fpu_a = a_q;
  assign fpu_b = b_q;
  assign fpu_opcode = op_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    out_d = out_q;
    flag_d = flag_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    if (acc) begin
      gid_d = gnt;
      cnt_d = CNT_W'(LATENCY);
      state_d = div ? RESP : WAIT;
      out_d = div ? 16'h7E00 : out_q;
      flag_d = div ? 6'b010000 : flag_q;
      a_d = div ? a_q : (gnt ? req_a1 : req_a0);
      b_d = div ? b_q : (gnt ? req_b1 : req_b0);
      op_d = div ? op_q : (gnt ? req_op1 : req_op0);
    end
    if (state_q == WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == '0) begin
        state_d = RESP;
        out_d = fpu_out;
        flag_d = fpu_flag;
      end
    end
    if (hs) begin
      state_d = IDLE;
      ptr_d = !gid_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ptr_q <= 1'b0;
      gid_q <= 1'b0;
      out_q <= '0;
      flag_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      out_q <= out_d;
      flag_q <= flag_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
    end
  end
`ifdef FPU_SCHED_STATS_EN
  logic [15:0] st0_q, st1_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st0_q <= '0;
      st1_q <= '0;
    end else begin
      if (req_ready0 && st0_q != 16'hFFFF) st0_q <= st0_q + 16'd1;
      if (req_ready1 && st1_q != 16'hFFFF) st1_q <= st1_q + 16'd1;
    end
  end
  assign stat_issue0 = st0_q;
  assign stat_issue1 = st1_q;
`else
  assign stat_issue0 = '0;
  assign stat_issue1 = '0;
`endif
endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: directed scoreboard bench for fpu_sched with a table-driven fpu stand-in.
module tb_fpu_sched #(parameter int LAT = 1);
  typedef struct {logic [15:0] a, b; logic [1:0] op; logic [15:0] o; logic [5:0] f;} vec_t;
  typedef struct {int id; logic [15:0] o; logic [5:0] f; int acc; int lat;} sb_t;
  logic clk = 0, rst_n;
  logic v[2], rdy[2], rr[2];
  logic [15:0] a[2], b[2], ea[2];
  logic [1:0] op[2];
  logic [5:0] ef[2];
  logic rsp_valid0, rsp_valid1, busy;
  logic [15:0] rsp_out, fpu_a, fpu_b, fpu_out, stat_issue0, stat_issue1;
  logic [5:0] rsp_flag, fpu_flag;
  logic [1:0] fpu_opcode;
  vec_t vq[2][$];
  sb_t sb[$];
  int grants[$];
  int tests = 0, fails = 0, cyc = 0, n_acc[2];
  logic pv = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fpu_sched #(.LATENCY(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(v[0]), .req_ready0(rdy[0]), .req_a0(a[0]), .req_b0(b[0]), .req_op0(op[0]),
    .req_valid1(v[1]), .req_ready1(rdy[1]), .req_a1(a[1]), .req_b1(b[1]), .req_op1(op[1]),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_ready0(rr[0]), .rsp_ready1(rr[1]),
    .rsp_out(rsp_out), .rsp_flag(rsp_flag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_out(fpu_out), .fpu_flag(fpu_flag),
    .busy(busy), .stat_issue0(stat_issue0), .stat_issue1(stat_issue1)
  );
  // fpu stand-in: known half-precision vectors, LAT-stage registered
  function automatic logic [21:0] fpu_fn(input logic [15:0] x, input logic [15:0] y, input logic [1:0] o);
    case ({o, x, y})
      {2'b00, 16'h3C00, 16'h4000}: return {16'h4200, 6'b000001};
      {2'b10, 16'h4000, 16'h4000}: return {16'h4400, 6'b000001};
      {2'b01, 16'h4200, 16'h3C00}: return {16'h4000, 6'b000001};
      {2'b00, 16'h3C00, 16'h3C00}: return {16'h4000, 6'b000001};
      {2'b10, 16'h3C00, 16'hC000}: return {16'hC000, 6'b000001};
      {2'b01, 16'h3C00, 16'h3C00}: return {16'h0000, 6'b000100};
      default: return {16'hDEAD, 6'b100000};
    endcase
  endfunction
  logic [21:0] pipe[LAT];
  always @(posedge clk) begin
    pipe[0] <= fpu_fn(fpu_a, fpu_b, fpu_opcode);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {fpu_out, fpu_flag} = pipe[LAT-1];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic run_drv(input int id);
    vec_t x;
    int n;
    forever begin
      @(posedge clk);
      #1 v[id] = 0;
      if (vq[id].size() != 0) begin
        x = vq[id].pop_front();
        a[id] = x.a; b[id] = x.b; op[id] = x.op; ea[id] = x.o; ef[id] = x.f; v[id] = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rdy[id] && n < 300);
        if (!rdy[id]) begin
          tests++; fails++;
          $display("FAIL accept_timeout: requester %0d never accepted", id);
        end
      end
    end
  endtask
  initial run_drv(0);
  initial run_drv(1);
  initial begin : monitor
    sb_t e;
    logic [1:0] rv;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete(); pv = 0; n_acc[0] = 0; n_acc[1] = 0;
      end else begin
        for (int i = 0; i < 2; i++)
          if (v[i] && rdy[i]) begin
            sb.push_back('{i, ea[i], ef[i], cyc, op[i] == 2'b11 ? 1 : LAT + 2});
            grants.push_back(i);
            n_acc[i]++;
          end
        rv = {rsp_valid1, rsp_valid0};
        if (rv != 2'b00) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding", rv);
          end else begin
            e = sb[0];
            if (!pv) chk("rsp_latency", cyc - e.acc, e.lat);
            chk("rsp_channel", rv, e.id == 1 ? 2 : 1);
            chk("rsp_out", rsp_out, e.o);
            chk("rsp_flag", rsp_flag, e.f);
            if (rr[e.id]) void'(sb.pop_front());
          end
        end
        pv = rv != 2'b00;
      end
    end
  end
  task automatic wait_idle(input string nm);
    int n;
    logic done;
    n = 0;
    done = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
      done = vq[0].size() == 0 && vq[1].size() == 0 && !v[0] && !v[1] && sb.size() == 0 && !busy;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s: did not drain within %0d cycles", nm, n);
    end
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_rsp_valid"}, {rsp_valid1, rsp_valid0}, 0);
    chk({nm, "_rsp_out"}, rsp_out, 0);
    chk({nm, "_rsp_flag"}, rsp_flag, 0);
    chk({nm, "_fpu"}, {fpu_a, fpu_b, fpu_opcode}, 0);
    chk({nm, "_stats"}, {stat_issue1, stat_issue0}, 0);
  endtask
  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask
  initial begin
    int n;
    rst_n = 0; v = '{0, 0}; rr = '{1, 1};
    a = '{0, 0}; b = '{0, 0}; op = '{0, 0}; ea = '{0, 0}; ef = '{0, 0};
    vq[0].push_back('{16'h3C00, 16'h4000, 2'b00, 16'h4200, 6'b000001});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", {rdy[1], rdy[0]}, 0);
    chk_reset("por");
    @(posedge clk); #1 rst_n = 1;
    wait_idle("add0");
    pulse_reset();
    @(negedge clk);
    grants.delete();
    vq[0].push_back('{16'h4000, 16'h4000, 2'b10, 16'h4400, 6'b000001});
    vq[0].push_back('{16'h3C00, 16'h3C00, 2'b00, 16'h4000, 6'b000001});
    vq[1].push_back('{16'h4200, 16'h3C00, 2'b01, 16'h4000, 6'b000001});
    vq[1].push_back('{16'h3C00, 16'hC000, 2'b10, 16'hC000, 6'b000001});
    wait_idle("rr");
    chk("grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("grant_order", grants[i], i % 2);
    @(negedge clk);
    vq[1].push_back('{16'h1234, 16'h5678, 2'b11, 16'h7E00, 6'b010000});
    wait_idle("div");
    chk("div_fpu_hold", {fpu_a, fpu_b, fpu_opcode}, {16'h3C00, 16'hC000, 2'b10});
    @(negedge clk);
    rr[0] = 0;
    vq[0].push_back('{16'h3C00, 16'h4000, 2'b00, 16'h4200, 6'b000001});
    vq[1].push_back('{16'h3C00, 16'h3C00, 2'b01, 16'h0000, 6'b000100});
    n = 0;
    while (!rsp_valid0 && n < 100) begin @(negedge clk); n++; end
    chk("bp_valid_seen", rsp_valid0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_busy", busy, 1);
      chk("bp_ready", {rdy[1], rdy[0]}, 0);
      chk("bp_valid", rsp_valid0, 1);
      @(negedge clk);
    end
    @(posedge clk); #1 rr[0] = 1;
    wait_idle("bp");
    @(negedge clk);
    vq[0].push_back('{16'h4000, 16'h4000, 2'b10, 16'h4400, 6'b000001});
    n = 0;
    do begin @(negedge clk); n++; end while (!(v[0] && rdy[0]) && n < 100);
    chk("rw_accept", v[0] && rdy[0], 1);
    pulse_reset();
    @(negedge clk);
    chk_reset("rst_wait");
    repeat (6) @(negedge clk);
    vq[1].push_back('{16'h3C00, 16'h4000, 2'b00, 16'h4200, 6'b000001});
    wait_idle("post_reset");
    @(negedge clk);
    for (int i = 0; i < 3; i++) vq[0].push_back('{16'h3C00, 16'h4000, 2'b00, 16'h4200, 6'b000001});
    vq[1].push_back('{16'h1234, 16'h5678, 2'b11, 16'h7E00, 6'b010000});
    vq[1].push_back('{16'h3C00, 16'hC000, 2'b10, 16'hC000, 6'b000001});
    wait_idle("stats");
`ifdef FPU_SCHED_STATS_EN
    chk("stat_issue0", stat_issue0, n_acc[0]);
    chk("stat_issue1", stat_issue1, n_acc[1]);
    chk("stat_issue0_val", stat_issue0, 3);
    chk("stat_issue1_val", stat_issue1, 3);
`else
    chk("stat_issue0", stat_issue0, 0);
    chk("stat_issue1", stat_issue1, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fpu_sched.md
Name: fpu_sched

Overview:
Two-requester scheduler that shares one registered fpu datapath (16-bit half-precision add/sub/mul, 2-bit opcode, 6-bit flag vector {snan,qnan,inf,zero,subnormal,normal}). It arbitrates between requesters round-robin and holds operands stable while the datapath computes. It captures the result and flags and returns them on a per-requester valid/ready response channel. Opcode 2'b11 (division) has no datapath in the fpu, so the scheduler intercepts it and answers it locally.

Parameters:
LATENCY, 1, clock edges from the fpu sampling its inputs to fpu_out/fpu_flag being valid; legal range 1..15.
CNT_W, 4, width of the internal wait counter; must satisfy 2^CNT_W > LATENCY.

Ports:
clk  in  1  rising-edge clock, the only clock.
rst_n  in  1  synchronous reset, active-low.
req_valid0  in  1  requester 0 has an operation.
req_ready0  out  1  requester 0 operation accepted this cycle.
req_a0, req_b0  in  16  requester 0 operands.
req_op0  in  2  requester 0 opcode: 00 add, 01 sub, 10 mul, 11 div.
req_valid1, req_ready1, req_a1, req_b1, req_op1  as above, for requester 1.
rsp_valid0 / rsp_valid1  out  1  response pending for requester 0 / 1.
rsp_ready0 / rsp_ready1  in  1  requester 0 / 1 accepts the response.
rsp_out  out  16  result, shared by both response channels.
rsp_flag  out  6  flags {snan,qnan,inf,zero,subnormal,normal}.
fpu_a, fpu_b  out  16  operands to the fpu.
fpu_opcode  out  2  opcode to the fpu.
fpu_out  in  16  fpu result.
fpu_flag  in  6  fpu flags.
busy  out  1  high when the state is not IDLE.
stat_issue0, stat_issue1  out  16  operations accepted per requester (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; wait counter 0; priority pointer to requester 0; rsp_valid0/1=0; rsp_out=0; rsp_flag=0; fpu_a=0; fpu_b=0; fpu_opcode=0; stat counters=0. While rst_n=0, req_ready0/1 are forced to 0.
- Reset mid-operation: any in-flight operation or pending response is discarded. No response is issued for it.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_readyN is combinational: high only in IDLE, for the granted requester.
  - Grant: if only one requester is valid, grant it. If both are valid, grant the requester selected by the priority pointer.
  - On accept in cycle T, the grant id is latched.
  - Opcode 00/01/10: operands and opcode load into fpu_a/fpu_b/fpu_opcode at the edge ending T. Counter loads LATENCY. Next state WAIT.
  - Opcode 11: fpu_* are unchanged. rsp_out=16'h7E00 and rsp_flag=6'b010000 are loaded. Next state RESP, so rsp_valid is high in T+1.
- WAIT:
  - fpu_* hold stable for the whole state.
  - The counter decrements each cycle.
  - In the cycle the counter equals 0, fpu_out/fpu_flag are registered into rsp_out/rsp_flag and the next state is RESP. WAIT therefore lasts LATENCY+1 cycles.
  - With LATENCY=1 and accept in cycle T, rsp_valid is first high in T+3.
- RESP:
  - rsp_validN is high only for the latched grant id. rsp_out/rsp_flag hold stable until the handshake.
  - On rsp_validN && rsp_readyN, the next state is IDLE and the priority pointer is set to the other requester, i.e. the one not just served. rsp_valid drops in the following cycle.
- Throughput: at most one operation in flight. The next accept is possible in the first IDLE cycle after the response handshake.
- A requester must hold req_* stable while req_valid is high and not yet accepted. The scheduler samples operands only on accept.
- A requester that is valid but not granted waits without loss. The round-robin pointer bounds its wait to one competing operation.

Optional Feature:
- Macro: FPU_SCHED_STATS_EN.
- Defined: stat_issueN increments by 1 on each accepted operation from requester N, division included. The counter saturates at 16'hFFFF. It clears only on reset.
- Undefined: no counter logic is built and stat_issue0/1 are tied to 0. All other behaviour is identical.

Test Plan:
- Req0 add, a=16'h3C00 (1.0), b=16'h4000 (2.0), accept in T, LATENCY=1, rsp_ready0=1 -> rsp_valid0 high in T+3; rsp_out=16'h4200; rsp_flag=6'b000001; rsp_valid1 stays 0.
- Both valid in the same cycle after reset, req0 mul, req1 sub -> req0 served first. Then req1 accepted in the first IDLE cycle after req0's handshake. With both still valid afterwards, grants alternate 0,1,0,1.
- Req1 op=11 -> fpu_* unchanged; rsp_valid1 high in the cycle after accept; rsp_out=16'h7E00; rsp_flag=6'b010000.
- Response backpressure: rsp_ready0=0 for 5 cycles -> rsp_valid0, rsp_out and rsp_flag stable; busy=1; req_ready0/1=0 throughout. Handshake completes on the first cycle rsp_ready0=1.
- rst_n=0 for one edge while in WAIT -> all outputs at reset values in the next cycle; no rsp_valid for the dropped operation; a fresh request is then accepted normally.
- LATENCY=3 with FPU_SCHED_STATS_EN defined, 3 ops from req0 and 2 from req1 -> each rsp_valid appears 5 cycles after its accept; stat_issue0=3 and stat_issue1=2.
